arcade_input_mapper: RTL and testbench

//  Parametrised per-player control mapper for arcade cores: merges USB, UserIO (DB9/DB15) and
//  PS/2 keyboard into per-player direction/button/start/coin outputs. Adds the orientation

---
 rtl/arcade_input_mapper_if.sv | 27 ++
 rtl/arcade_input_mapper.sv | 240 ++++++++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/arcade_input_mapper_if.sv
// Control bus between the joystick/keyboard drivers and the mapper. The input side
// carries raw controller words; the output side carries the per-player game controls.
interface arcade_input_mapper_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_BUTTONS = 2
);
  logic [10:0]                        ps2_key;
  logic [16*NUM_PLAYERS-1:0]          joy_usb;
  logic [16*NUM_PLAYERS-1:0]          joy_db;
  logic                               db_ena;
  logic [1:0]                         rotate;
  logic                               coin_auto;
  logic [NUM_PLAYERS-1:0]             autofire_en;
  logic [4*NUM_PLAYERS-1:0]           p_dir;
  logic [NUM_BUTTONS*NUM_PLAYERS-1:0] p_btn;
  logic [NUM_PLAYERS-1:0]             p_start;
  logic [NUM_PLAYERS-1:0]             p_coin;

  modport master (
    output ps2_key, joy_usb, joy_db, db_ena, rotate, coin_auto, autofire_en,
    input  p_dir, p_btn, p_start, p_coin
  );
  modport slave (
    input  ps2_key, joy_usb, joy_db, db_ena, rotate, coin_auto, autofire_en,
    output p_dir, p_btn, p_start, p_coin
  );
endinterface

// File: rtl/arcade_input_mapper.sv
// Per-player arcade control mapper: merges USB, UserIO and PS/2 keyboard, then applies
// rotation, SOCD cleaning, button-0 autofire and timed coin pulses with holdoff.
module arcade_input_mapper_lane #(
  parameter int NUM_BUTTONS    = 2,
  parameter int COIN_PULSE_CYC = 240000
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [5+NUM_BUTTONS:0] word,
  input  logic [1:0]             rotate,
  input  logic                   coin_auto,
  input  logic                   autofire_en,
  input  logic                   af_tick,
  output logic [3:0]             dir,
  output logic [NUM_BUTTONS-1:0] btn,
  output logic                   start,
  output logic                   coin
);
  localparam int CW = $clog2(COIN_PULSE_CYC + 1);

  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} coin_state_t;

  logic u, d, l, r, ru, rd, rl, rr;
  logic [3:0] dir_d;
  logic [NUM_BUTTONS-1:0] btn_raw, btn_d;
  logic b0_prev, coin_prev, start_prev, trig;
  logic coin_in, start_in;
  coin_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  assign {u, d, l, r} = word[3:0];
  assign btn_raw  = word[4 +: NUM_BUTTONS];
  assign start_in = word[4+NUM_BUTTONS];
  assign coin_in  = word[5+NUM_BUTTONS];

  always_comb begin
    {ru, rd, rl, rr} = {u, d, l, r};
    case (rotate)
      2'd1:    {ru, rd, rl, rr} = {l, r, d, u};
      2'd2:    {ru, rd, rl, rr} = {r, l, u, d};
      2'd3:    {ru, rd, rl, rr} = {d, u, r, l};
      default: ;
    endcase
  end

  // Opposing directions cancel after rotation; output order is {R,L,D,U}.
  assign dir_d = {rr & ~rl, rl & ~rr, rd & ~ru, ru & ~rd};

  // Autofire: fire on the first held cycle, then flip on every shared divider tick.
  always_comb begin
    btn_d = btn_raw;
    if (autofire_en) begin
      if (!btn_raw[0])   btn_d[0] = 1'b0;
      else if (!b0_prev) btn_d[0] = 1'b1;
      else if (af_tick)  btn_d[0] = ~btn[0];
      else               btn_d[0] = btn[0];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dir     <= '0;
      btn     <= '0;
      start   <= 1'b0;
      b0_prev <= 1'b0;
    end else begin
      dir     <= dir_d;
      btn     <= btn_d;
      start   <= start_in;
      b0_prev <= btn_raw[0];
    end
  end

  // Edge memories track the level every cycle so a level held through holdoff cannot retrigger.
  assign trig = (coin_in & ~coin_prev) | (coin_auto & start_in & ~start_prev);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      coin_prev  <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      coin_prev  <= coin_in;
      start_prev <= start_in;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (trig) begin
        state_n = PULSE;
        cnt_n   = '0;
      end
      PULSE: if (cnt == CW'(COIN_PULSE_CYC - 1)) begin
        state_n = HOLDOFF;
        cnt_n   = '0;
      end else cnt_n = cnt + CW'(1);
      HOLDOFF: if (cnt == CW'(COIN_PULSE_CYC - 1)) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else cnt_n = cnt + CW'(1);
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign coin = (state == PULSE);
endmodule

module arcade_input_mapper #(
  parameter int NUM_PLAYERS    = 2,
  parameter int NUM_BUTTONS    = 2,
  parameter int COIN_PULSE_CYC = 240000,
  parameter int AUTOFIRE_DIV   = 600000
) (
  input logic                 clk_sys,
  input logic                 reset,
  arcade_input_mapper_if.slave bus
);
  localparam int DW = $clog2(AUTOFIRE_DIV + 1);
  localparam int W  = 6 + NUM_BUTTONS;

  localparam int K0U = 0,  K0D = 1,  K0L = 2,  K0R = 3,  K0B0A = 4, K0B0B = 5, K0B1 = 6;
  localparam int K0SA = 7, K0SB = 8, K0C = 9;
  localparam int K1U = 10, K1D = 11, K1L = 12, K1R = 13, K1B0 = 14, K1B1 = 15;
  localparam int K1SA = 16, K1SB = 17, K1C = 18;

  logic        ps2_tog;
  logic [18:0] key;
  logic [DW-1:0] div_cnt;
  logic        af_tick;

  logic [NUM_PLAYERS-1:0][15:0]            usb_w, db_w, kbd_word, merged;
  logic [NUM_PLAYERS-1:0][3:0]             dir_w;
  logic [NUM_PLAYERS-1:0][NUM_BUTTONS-1:0] btn_w;
  logic [NUM_PLAYERS-1:0]                  start_w, coin_w;

  function automatic logic [15:0] kmap(input logic ku, kd, kl, kr, kb0, kb1, kst, kcn);
    logic [15:0] w;
    w    = '0;
    w[0] = kr;
    w[1] = kl;
    w[2] = kd;
    w[3] = ku;
    w[4] = kb0;
    if (NUM_BUTTONS > 1) w[5] = kb1;
    w[4+NUM_BUTTONS] = kst;
    w[5+NUM_BUTTONS] = kcn;
    return w;
  endfunction

  // A PS/2 event is signalled by bit 10 changing; the copy is seeded at reset so release is quiet.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ps2_tog <= bus.ps2_key[10];
      key     <= '0;
    end else begin
      ps2_tog <= bus.ps2_key[10];
      if (bus.ps2_key[10] != ps2_tog) begin
        case (bus.ps2_key[8:0])
          9'h175: key[K0U]   <= bus.ps2_key[9];
          9'h172: key[K0D]   <= bus.ps2_key[9];
          9'h16B: key[K0L]   <= bus.ps2_key[9];
          9'h174: key[K0R]   <= bus.ps2_key[9];
          9'h029: key[K0B0A] <= bus.ps2_key[9];
          9'h014: key[K0B0B] <= bus.ps2_key[9];
          9'h011: key[K0B1]  <= bus.ps2_key[9];
          9'h005: key[K0SA]  <= bus.ps2_key[9];
          9'h016: key[K0SB]  <= bus.ps2_key[9];
          9'h02E: key[K0C]   <= bus.ps2_key[9];
          9'h02D: key[K1U]   <= bus.ps2_key[9];
          9'h02B: key[K1D]   <= bus.ps2_key[9];
          9'h023: key[K1L]   <= bus.ps2_key[9];
          9'h034: key[K1R]   <= bus.ps2_key[9];
          9'h01C: key[K1B0]  <= bus.ps2_key[9];
          9'h01B: key[K1B1]  <= bus.ps2_key[9];
          9'h006: key[K1SA]  <= bus.ps2_key[9];
          9'h01E: key[K1SB]  <= bus.ps2_key[9];
          9'h036: key[K1C]   <= bus.ps2_key[9];
          default: ;
        endcase
      end
    end
  end

  assign af_tick = (div_cnt == DW'(AUTOFIRE_DIV - 1));

  always_ff @(posedge clk_sys) begin
    if (reset)        div_cnt <= '0;
    else if (af_tick) div_cnt <= '0;
    else              div_cnt <= div_cnt + DW'(1);
  end

  always_comb begin
    kbd_word    = '0;
    kbd_word[0] = kmap(key[K0U], key[K0D], key[K0L], key[K0R], key[K0B0A] | key[K0B0B],
                       key[K0B1], key[K0SA] | key[K0SB], key[K0C]);
    for (int p = 1; p < NUM_PLAYERS && p < 2; p++)
      kbd_word[p] = kmap(key[K1U], key[K1D], key[K1L], key[K1R], key[K1B0],
                         key[K1B1], key[K1SA] | key[K1SB], key[K1C]);
  end

  assign usb_w = bus.joy_usb;
  assign db_w  = bus.joy_db;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic unused_hi;
    assign merged[p] = usb_w[p] | (bus.db_ena ? db_w[p] : 16'h0) | kbd_word[p];
    assign unused_hi = ^merged[p][15:W];

    arcade_input_mapper_lane #(
      .NUM_BUTTONS   (NUM_BUTTONS),
      .COIN_PULSE_CYC(COIN_PULSE_CYC)
    ) u_lane (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .word       (merged[p][W-1:0]),
      .rotate     (bus.rotate),
      .coin_auto  (bus.coin_auto),
      .autofire_en(bus.autofire_en[p]),
      .af_tick    (af_tick),
      .dir        (dir_w[p]),
      .btn        (btn_w[p]),
      .start      (start_w[p]),
      .coin       (coin_w[p])
    );
  end

  assign bus.p_dir   = dir_w;
  assign bus.p_btn   = btn_w;
  assign bus.p_start = start_w;
  assign bus.p_coin  = coin_w;
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Randomized bench for arcade_input_mapper against a timestamp/table reference model,
// preceded by short directed scenarios for rotation, SOCD, keyboard, coin and autofire.
module tb_arcade_input_mapper;
  localparam int NP = 2, NB = 2, CP = 5, AD = 4;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  arcade_input_mapper_if #(.NUM_PLAYERS(NP), .NUM_BUTTONS(NB)) bus ();

  arcade_input_mapper #(
    .NUM_PLAYERS(NP), .NUM_BUTTONS(NB), .COIN_PULSE_CYC(CP), .AUTOFIRE_DIV(AD)
  ) dut (
    .clk_sys(clk), .reset(reset), .bus(bus)
  );

  int n_vec = 0, n_err = 0;

  // reference model state
  bit  kd [512];
  bit  tog_m;
  int  edge_no = 0, since = 0;
  int  last_trig [NP];
  bit  coin_prev [NP], start_prev [NP], b0_prev [NP];
  logic [4*NP-1:0]  e_dir;
  logic [NB*NP-1:0] e_btn;
  logic [NP-1:0]    e_start, e_coin;
  // src[rotate][out] = which input direction feeds output (0 U, 1 D, 2 L, 3 R)
  int src [4][4] = '{'{0, 1, 2, 3}, '{2, 3, 1, 0}, '{3, 2, 0, 1}, '{1, 0, 3, 2}};
  int codes [20] = '{'h175, 'h172, 'h16B, 'h174, 'h029, 'h014, 'h011, 'h005, 'h016, 'h02E,
                     'h02D, 'h02B, 'h023, 'h034, 'h01C, 'h01B, 'h006, 'h01E, 'h036, 'h01D};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] kword(input int p);
    logic [15:0] w;
    w = '0;
    if (p == 0) begin
      w[3] = kd['h175]; w[2] = kd['h172]; w[1] = kd['h16B]; w[0] = kd['h174];
      w[4] = kd['h029] | kd['h014]; w[5] = kd['h011];
      w[4+NB] = kd['h005] | kd['h016]; w[5+NB] = kd['h02E];
    end else if (p == 1) begin
      w[3] = kd['h02D]; w[2] = kd['h02B]; w[1] = kd['h023]; w[0] = kd['h034];
      w[4] = kd['h01C]; w[5] = kd['h01B];
      w[4+NB] = kd['h006] | kd['h01E]; w[5+NB] = kd['h036];
    end
    return w;
  endfunction

  task automatic model_step();
    logic [15:0] w;
    bit [3:0] in4, o;
    logic [NB-1:0] b;
    bit tk, trig;
    if (reset) begin
      foreach (kd[i]) kd[i] = 1'b0;
      tog_m = bus.ps2_key[10];
      since = 0;
      e_dir = '0; e_btn = '0; e_start = '0; e_coin = '0;
      for (int p = 0; p < NP; p++) begin
        last_trig[p] = -1000000; coin_prev[p] = 0; start_prev[p] = 0; b0_prev[p] = 0;
      end
    end else begin
      tk = (since % AD) == AD - 1;
      since++;
      for (int p = 0; p < NP; p++) begin
        w = bus.joy_usb[16*p +: 16] | (bus.db_ena ? bus.joy_db[16*p +: 16] : 16'h0) | kword(p);
        in4 = {w[0], w[1], w[2], w[3]};
        for (int k = 0; k < 4; k++) o[k] = in4[src[bus.rotate][k]];
        if (o[0] && o[1]) begin o[0] = 0; o[1] = 0; end
        if (o[2] && o[3]) begin o[2] = 0; o[3] = 0; end
        e_dir[4*p +: 4] = o;
        b = w[4 +: NB];
        if (bus.autofire_en[p]) begin
          if (!w[4])            b[0] = 1'b0;
          else if (!b0_prev[p]) b[0] = 1'b1;
          else if (tk)          b[0] = ~e_btn[NB*p];
          else                  b[0] = e_btn[NB*p];
        end
        b0_prev[p] = w[4];
        e_btn[NB*p +: NB] = b;
        e_start[p] = w[4+NB];
        trig = (w[5+NB] && !coin_prev[p]) || (bus.coin_auto && w[4+NB] && !start_prev[p]);
        if (trig && edge_no > last_trig[p] + 2*CP) last_trig[p] = edge_no;
        e_coin[p] = (edge_no >= last_trig[p]) && (edge_no < last_trig[p] + CP);
        coin_prev[p] = w[5+NB];
        start_prev[p] = w[4+NB];
      end
      if (bus.ps2_key[10] != tog_m) begin
        tog_m = bus.ps2_key[10];
        kd[bus.ps2_key[8:0]] = bus.ps2_key[9];
      end
    end
    edge_no++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("p_dir",   32'(bus.p_dir),   32'(e_dir));
    chk("p_btn",   32'(bus.p_btn),   32'(e_btn));
    chk("p_start", 32'(bus.p_start), 32'(e_start));
    chk("p_coin",  32'(bus.p_coin),  32'(e_coin));
  endtask

  task automatic send_key(input bit pressed, input logic [8:0] code);
    bus.ps2_key = {~bus.ps2_key[10], pressed, code};
  endtask

  initial begin
    int hi, rises;
    logic prev_c;
    logic [16*NP-1:0] tmp;
    bus.ps2_key = '0; bus.joy_usb = '0; bus.joy_db = '0; bus.db_ena = 1'b0;
    bus.rotate = 2'd0; bus.coin_auto = 1'b0; bus.autofire_en = '0;
    reset = 1'b1;
    tick(); tick();
    chk("rst_dir", 32'(bus.p_dir), 32'h0);
    chk("rst_coin", 32'(bus.p_coin), 32'h0);
    reset = 1'b0;

    bus.joy_usb = 32'h0000_0008; bus.rotate = 2'd1; tick();
    chk("cw_up_to_r", 32'(bus.p_dir[3:0]), 32'h8);
    bus.rotate = 2'd0; bus.joy_usb = 32'h3; tick();
    chk("socd_lr", 32'(bus.p_dir[3:0]), 32'h0);
    bus.joy_usb = 32'hD; tick();
    chk("socd_udr", 32'(bus.p_dir[3:0]), 32'h8);
    bus.joy_usb = '0;

    send_key(1'b1, 9'h175); tick();
    chk("kbd_lat1", 32'(bus.p_dir[0]), 32'h0);
    tick();
    chk("kbd_up", 32'(bus.p_dir[0]), 32'h1);
    send_key(1'b0, 9'h175); tick(); tick();
    chk("kbd_rel", 32'(bus.p_dir[0]), 32'h0);

    // coin held far longer than pulse+holdoff: one pulse of exactly CP cycles
    hi = 0; rises = 0; prev_c = 1'b0;
    bus.joy_usb = 32'(1) << (5 + NB);
    for (int i = 0; i < 60; i++) begin
      tick();
      hi += int'(bus.p_coin[0]);
      if (bus.p_coin[0] && !prev_c) rises++;
      prev_c = bus.p_coin[0];
    end
    chk("coin_len", 32'(hi), 32'(CP));
    chk("coin_pulses", 32'(rises), 32'h1);
    bus.joy_usb = '0;
    for (int i = 0; i < 2*CP + 2; i++) tick();

    // coin_auto: start edge makes a pulse; a fresh start edge during holdoff does not
    bus.coin_auto = 1'b1;
    bus.joy_usb = 32'(1) << (4 + NB); tick();
    chk("auto_start", 32'(bus.p_start[0]), 32'h1);
    chk("auto_coin", 32'(bus.p_coin[0]), 32'h1);
    hi = 1;
    for (int i = 1; i < 30; i++) begin
      if (i == CP + 1) bus.joy_usb = '0;
      if (i == CP + 2) bus.joy_usb = 32'(1) << (4 + NB);
      tick();
      hi += int'(bus.p_coin[0]);
    end
    chk("auto_holdoff", 32'(hi), 32'(CP));
    bus.coin_auto = 1'b0; bus.joy_usb = '0; tick();

    // autofire on P0 button 0, then reset in the middle of it
    bus.autofire_en = 2'b01; bus.joy_usb = 32'h10; tick();
    chk("af_first", 32'(bus.p_btn[0]), 32'h1);
    for (int i = 0; i < 4*AD; i++) tick();
    bus.joy_usb = 32'h10 | (32'(1) << (5 + NB));
    tick(); tick();
    reset = 1'b1; tick();
    chk("rst_mid", 32'({bus.p_dir, bus.p_btn, bus.p_start, bus.p_coin}), 32'h0);
    reset = 1'b0; bus.joy_usb = '0; bus.autofire_en = '0;
    tick();

    for (int i = 0; i < 4000; i++) begin
      int r, p, bt;
      r = int'($urandom_range(0, 99));
      p = int'($urandom_range(0, NP - 1));
      bt = int'($urandom_range(0, 5 + NB));
      if (r < 30) begin
        tmp = bus.joy_usb; tmp[16*p + bt] = ~tmp[16*p + bt]; bus.joy_usb = tmp;
      end else if (r < 40) begin
        tmp = bus.joy_db; tmp[16*p + bt] = ~tmp[16*p + bt]; bus.joy_db = tmp;
      end else if (r < 52) begin
        send_key(1'($urandom_range(0, 1)), 9'(codes[$urandom_range(0, 19)]));
      end else if (r < 55) bus.rotate = 2'($urandom);
      else if (r < 58) bus.db_ena = ~bus.db_ena;
      else if (r < 60) bus.coin_auto = ~bus.coin_auto;
      else if (r < 63) bus.autofire_en = NP'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
